// File: rtl/ps2_pkg.sv
// Shared constants and frame helpers for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam int unsigned FRAME_BITS      = 11;
  localparam int unsigned FIFO_DEPTH_DEF  = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 2000;

  // Frame layout, LSB first: start, data[7:0], parity, stop.
  function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
    return !f[0] && f[10] && (^f[9:1]);
  endfunction

  function automatic logic [7:0] frame_byte(input logic [FRAME_BITS-1:0] f);
    return f[8:1];
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous show-ahead byte FIFO; a push while full is accepted only alongside a pop.
module ps2_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CW'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata   = empty ? 8'h00 : mem[rd_ptr_q];
    count   = count_q;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard receiver: synchronizes the line, assembles 11-bit frames and buffers
// good scan codes in a FIFO with overflow and frame-error reporting.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          ready,
  output logic [7:0]                    data,
  output logic                          valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          frame_err,
  output logic                          busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic                  clk_meta_q, clk_sync_q, clk_prev_q;
  logic                  data_meta_q, data_sync_q;
  logic [FRAME_BITS-2:0] frame_q;
  logic [3:0]            bit_cnt_q;
  logic [TW-1:0]         idle_q;
  logic                  overflow_q, frame_err_q;

  logic                  fall, stop_edge, good_push, pop, drop;
  logic                  fifo_full, fifo_empty;
  logic [FRAME_BITS-1:0] frame_next;

  always_comb begin
    fall       = clk_prev_q && !clk_sync_q;
    frame_next = {data_sync_q, frame_q};
    stop_edge  = fall && (bit_cnt_q == 4'(FRAME_BITS - 1));
    good_push  = stop_edge && frame_ok(frame_next);
    pop        = valid && ready;
    drop       = good_push && fifo_full && !pop;
    valid      = !fifo_empty;
    busy       = (bit_cnt_q != '0);
    overflow   = overflow_q;
    frame_err  = frame_err_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      frame_q     <= '0;
      bit_cnt_q   <= '0;
      idle_q      <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
      frame_err_q <= stop_edge && !frame_ok(frame_next);

      if (fall) begin
        frame_q   <= frame_next[FRAME_BITS-1:1];
        idle_q    <= '0;
        bit_cnt_q <= stop_edge ? 4'd0 : bit_cnt_q + 4'd1;
      end else if (busy) begin
        // A stalled keyboard must not leave us mid-frame forever.
        if (idle_q == TW'(TIMEOUT_CYC - 1)) begin
          bit_cnt_q <= '0;
          idle_q    <= '0;
        end else begin
          idle_q <= idle_q + 1'b1;
        end
      end else begin
        idle_q <= '0;
      end

      if (drop)     overflow_q <= 1'b1;
      else if (pop) overflow_q <= 1'b0;
    end
  end

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (good_push),
    .wdata (frame_byte(frame_next)),
    .pop   (pop),
    .rdata (data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: frames, parity error, overflow, timeout, full+pop, reset.
module tb_ps2_kbd_ctrl;
  import ps2_pkg::*;

  localparam int unsigned DEPTH = FIFO_DEPTH_DEF;
  localparam int unsigned TOUT  = TIMEOUT_CYC_DEF;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic [$clog2(DEPTH):0] count;
  logic       overflow, frame_err, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int err_cycles = 0;
  int valid_cycles = 0;

  always #5 clk = ~clk;

  ps2_kbd_ctrl u_dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ready     (ready),
    .data      (data),
    .valid     (valid),
    .count     (count),
    .overflow  (overflow),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (frame_err) err_cycles++;
    if (valid) valid_cycles++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Falling edge reaches the detect cycle two posedges after it is driven; ready is
  // raised exactly around that posedge when pop_here is set.
  task automatic send_bit(input logic b, input logic pop_here);
    @(negedge clk);
    ps2_data = b;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
    if (pop_here) begin
      @(negedge clk);
      @(negedge clk);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      repeat (3) @(negedge clk);
    end else begin
      repeat (6) @(negedge clk);
    end
    ps2_clk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic pop_stop);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i], (i == 10) && pop_stop);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) send_bit(f[i], 1'b0);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check_eq(tag, {24'h0, data}, {24'h0, exp});
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  initial begin
    logic [10:0] fr;
    repeat (3) @(negedge clk);
    check_eq("reset_valid", {31'h0, valid}, 32'd0);
    check_eq("reset_count", 32'(count), 32'd0);
    check_eq("reset_busy", {31'h0, busy}, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Single good frame, then consume it.
    err_cycles = 0;
    send_frame(8'h1C, 1'b0, 1'b0);
    check_eq("t1_valid", {31'h0, valid}, 32'd1);
    check_eq("t1_data", {24'h0, data}, 32'h1C);
    check_eq("t1_count", 32'(count), 32'd1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    check_eq("t1_valid_after_pop", {31'h0, valid}, 32'd0);
    check_eq("t1_no_err", 32'(err_cycles), 32'd0);

    // Parity error.
    err_cycles = 0;
    valid_cycles = 0;
    send_frame(8'h1C, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("t2_err_cycles", 32'(err_cycles), 32'd1);
    check_eq("t2_valid_cycles", 32'(valid_cycles), 32'd0);
    check_eq("t2_count", 32'(count), 32'd0);

    // Overflow on the ninth frame.
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
    check_eq("t3_count", 32'(count), 32'd8);
    check_eq("t3_overflow", {31'h0, overflow}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      pop_check("t3_pop", 8'(i));
      if (i == 1) check_eq("t3_ovf_cleared", {31'h0, overflow}, 32'd0);
    end
    @(negedge clk);
    check_eq("t3_empty", {31'h0, valid}, 32'd0);

    // Partial frame abandoned by timeout.
    err_cycles = 0;
    fr = 11'b111_0011_0010;
    send_bits(fr, 5);
    check_eq("t4_busy_mid", {31'h0, busy}, 32'd1);
    repeat (TOUT - 50) @(negedge clk);
    check_eq("t4_busy_before_to", {31'h0, busy}, 32'd1);
    repeat (60) @(negedge clk);
    check_eq("t4_busy_after_to", {31'h0, busy}, 32'd0);
    send_frame(8'hF0, 1'b0, 1'b0);
    check_eq("t4_data", {24'h0, data}, 32'hF0);
    check_eq("t4_count", 32'(count), 32'd1);
    check_eq("t4_no_err", 32'(err_cycles), 32'd0);
    pop_check("t4_pop", 8'hF0);

    // Full FIFO with a pop coinciding with the stop-bit detect cycle.
    for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 1'b0, 1'b0);
    check_eq("t5_full", 32'(count), 32'd8);
    send_frame(8'hAA, 1'b0, 1'b1);
    check_eq("t5_count", 32'(count), 32'd8);
    check_eq("t5_overflow", {31'h0, overflow}, 32'd0);
    for (int i = 1; i < 8; i++) pop_check("t5_pop", 8'(8'h10 + i));
    pop_check("t5_last", 8'hAA);
    @(negedge clk);
    check_eq("t5_empty", 32'(count), 32'd0);

    // Reset mid-frame with a byte buffered.
    send_frame(8'h33, 1'b0, 1'b0);
    fr = 11'b101_0101_1010;
    send_bits(fr, 6);
    check_eq("t6_busy_pre", {31'h0, busy}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("t6_rst_valid", {31'h0, valid}, 32'd0);
    check_eq("t6_rst_count", 32'(count), 32'd0);
    check_eq("t6_rst_ovf", {31'h0, overflow}, 32'd0);
    check_eq("t6_rst_err", {31'h0, frame_err}, 32'd0);
    check_eq("t6_rst_busy", {31'h0, busy}, 32'd0);
    check_eq("t6_rst_data", {24'h0, data}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    err_cycles = 0;
    send_frame(8'h5A, 1'b0, 1'b0);
    check_eq("t6_data", {24'h0, data}, 32'h5A);
    check_eq("t6_count", 32'(count), 32'd1);
    check_eq("t6_no_err", 32'(err_cycles), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
